// File: rtl/fifo_async_pkg.sv
// fifo_async_pkg: shared Gray-code conversion helpers for the FIFO pointer crossing.
package fifo_async_pkg;

    // Widest pointer the helpers handle; narrower pointers are zero-extended.
    localparam int unsigned GRAY_MAX_W = 32;

    // Binary to Gray; the upper bits of a zero-extended input stay zero.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary; each bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = '0;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_async_if.sv
// fifo_async_if: producer/consumer signal bundle for fifo_async.
interface fifo_async_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 4
) ();
    logic                  i_wr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [PTR_WIDTH:0]    o_wfill;
    logic                  o_wfull;
    logic                  o_walmostfull;
    logic                  i_rd;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic [PTR_WIDTH:0]    o_rfill;
    logic                  o_rempty;
    logic                  o_ralmostempty;

    // Producer/consumer side.
    modport master (
        output i_wr, i_wdata, i_rd,
        input  o_wfill, o_wfull, o_walmostfull,
        input  o_rdata, o_rfill, o_rempty, o_ralmostempty
    );

    // FIFO side.
    modport slave (
        input  i_wr, i_wdata, i_rd,
        output o_wfill, o_wfull, o_walmostfull,
        output o_rdata, o_rfill, o_rempty, o_ralmostempty
    );
endinterface

// File: rtl/fifo_async_sync2.sv
// fifo_async_sync2: two-flop synchronizer carrying a Gray pointer to the opposite side.
module fifo_async_sync2 #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/fifo_async.sv
// fifo_async: single-clock FIFO whose write and read sides see each other's pointer
// only through a Gray register plus a two-flop synchronizer, so the flags behave
// exactly like a dual-clock FIFO and the design can later be split into two domains.
module fifo_async
    import fifo_async_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned PTR_WIDTH          = 4,
    parameter int unsigned ALMOSTFULL_OFFSET  = 2,
    parameter int unsigned ALMOSTEMPTY_OFFSET = 2
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    fifo_async_if.slave  io_bus
);

    localparam int unsigned AW    = PTR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << PTR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wgray;
    logic [AW-1:0] r_rgray;

    logic [AW-1:0] w_wgray_sync;
    logic [AW-1:0] w_rgray_sync;
    logic [AW-1:0] w_wptr_sync;
    logic [AW-1:0] w_rptr_sync;
    logic [AW-1:0] w_wfill;
    logic [AW-1:0] w_rfill;
    logic          w_wfull;
    logic          w_rempty;
    logic          w_wr_ok;
    logic          w_rd_ok;

    // Acceptance: full writes and empty reads are dropped without side effects.
    assign w_wr_ok = io_bus.i_wr && !w_wfull;
    assign w_rd_ok = io_bus.i_rd && !w_rempty;

    // Storage array, intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[PTR_WIDTH-1:0]] <= io_bus.i_wdata;
        end
    end

    // Write pointer and its Gray image registered from the current pointer value.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_wgray <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_wgray <= AW'(bin2gray(GRAY_MAX_W'(r_wptr)));
        end
    end

    // Read pointer and its Gray image registered from the current pointer value.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rptr  <= '0;
            r_rgray <= '0;
        end else begin
            if (w_rd_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_rgray <= AW'(bin2gray(GRAY_MAX_W'(r_rptr)));
        end
    end

    // Write pointer into the read side.
    fifo_async_sync2 #(
        .WIDTH (AW)
    ) u_sync_w2r (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (r_wgray),
        .o_q    (w_wgray_sync)
    );

    // Read pointer into the write side.
    fifo_async_sync2 #(
        .WIDTH (AW)
    ) u_sync_r2w (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (r_rgray),
        .o_q    (w_rgray_sync)
    );

    // Back to binary and modulo-2**AW occupancy on each side.
    assign w_wptr_sync = AW'(gray2bin(GRAY_MAX_W'(w_wgray_sync)));
    assign w_rptr_sync = AW'(gray2bin(GRAY_MAX_W'(w_rgray_sync)));
    assign w_wfill     = r_wptr - w_rptr_sync;
    assign w_rfill     = w_wptr_sync - r_rptr;
    assign w_wfull     = (w_wfill == AW'(DEPTH));
    assign w_rempty    = (w_rfill == '0);

    // Status and head word, all decoded from registers only.
    assign io_bus.o_wfill        = w_wfill;
    assign io_bus.o_wfull        = w_wfull;
    assign io_bus.o_walmostfull  = (w_wfill >= AW'(DEPTH - ALMOSTFULL_OFFSET));
    assign io_bus.o_rfill        = w_rfill;
    assign io_bus.o_rempty       = w_rempty;
    assign io_bus.o_ralmostempty = (w_rfill <= AW'(ALMOSTEMPTY_OFFSET));
    assign io_bus.o_rdata        = r_mem[r_rptr[PTR_WIDTH-1:0]];

endmodule

// File: tb/tb_fifo_async.sv
// tb_fifo_async: scoreboard bench with a pointer/delay-line reference model for fifo_async.
module tb_fifo_async;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    fifo_async_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    fifo_async #(
        .DATA_WIDTH         (DW),
        .PTR_WIDTH          (PW),
        .ALMOSTFULL_OFFSET  (2),
        .ALMOSTEMPTY_OFFSET (2)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_bus (bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pop = 0;
    string      phase = "init";
    logic [7:0] sb [$];

    // Reference model: pointers mod 32 plus 3-deep histories of the opposite pointer.
    int m_wp = 0;
    int m_rp = 0;
    int hw [3] = '{0, 0, 0};
    int hr [3] = '{0, 0, 0};

    function automatic int m_wfill();
        return (m_wp - hr[2]) & 31;
    endfunction

    function automatic int m_rfill();
        return (hw[2] - m_rp) & 31;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        chk("wfill",        32'(bus.o_wfill),        m_wfill());
        chk("wfull",        32'(bus.o_wfull),        int'(m_wfill() == 16));
        chk("walmostfull",  32'(bus.o_walmostfull),  int'(m_wfill() >= 14));
        chk("rfill",        32'(bus.o_rfill),        m_rfill());
        chk("rempty",       32'(bus.o_rempty),       int'(m_rfill() == 0));
        chk("ralmostempty", 32'(bus.o_ralmostempty), int'(m_rfill() <= 2));
    endtask

    // One clock: drive, pop/compare head word, advance model, check flags on the falling edge.
    task automatic cyc(input bit wr, input logic [7:0] d, input bit rd);
        bit         wa;
        bit         ra;
        logic [7:0] e;
        wa = rstn && wr && (m_wfill() != 16);
        ra = rstn && rd && (m_rfill() != 0);
        bus.i_wr    = wr;
        bus.i_wdata = d;
        bus.i_rd    = rd;
        if (ra && sb.size() != 0) begin
            e = sb.pop_front();
            chk("rdata", 32'(bus.o_rdata), int'(e));
            n_pop++;
        end
        if (wa) sb.push_back(d);
        @(posedge clk);
        if (!rstn) begin
            m_wp = 0;
            m_rp = 0;
            hw   = '{0, 0, 0};
            hr   = '{0, 0, 0};
            sb.delete();
        end else begin
            hw[2] = hw[1]; hw[1] = hw[0]; hw[0] = m_wp;
            hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = m_rp;
            if (wa) m_wp = (m_wp + 1) & 31;
            if (ra) m_rp = (m_rp + 1) & 31;
        end
        @(negedge clk);
        check_flags();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_wfill",        32'(bus.o_wfill),        0);
        chk("rst_wfull",        32'(bus.o_wfull),        0);
        chk("rst_walmostfull",  32'(bus.o_walmostfull),  0);
        chk("rst_rfill",        32'(bus.o_rfill),        0);
        chk("rst_rempty",       32'(bus.o_rempty),       1);
        chk("rst_ralmostempty", 32'(bus.o_ralmostempty), 1);
    endtask

    // Global time limit.
    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, ran %0d / needed < 1ms", n_cmp);
        $fatal(1, "time limit");
    end

    initial begin
        int start_pop;
        int nw;
        bit wr;
        bit rd;

        rstn        = 1'b0;
        bus.i_wr    = 1'b0;
        bus.i_wdata = '0;
        bus.i_rd    = 1'b0;

        phase = "reset";
        idle(2);
        rstn = 1'b1;
        check_reset_values();

        phase = "single";
        cyc(1'b1, 8'hA5, 1'b0);
        chk("wfill_after_n", 32'(bus.o_wfill), 1);
        chk("rempty_after_n", 32'(bus.o_rempty), 1);
        idle(2);
        chk("rempty_after_n2", 32'(bus.o_rempty), 1);
        idle(1);
        chk("rempty_after_n3", 32'(bus.o_rempty), 0);
        chk("rdata_after_n3", 32'(bus.o_rdata), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1);
        chk("rempty_after_pop", 32'(bus.o_rempty), 1);
        idle(2);
        chk("wfill_pop_m2", 32'(bus.o_wfill), 1);
        idle(1);
        chk("wfill_pop_m3", 32'(bus.o_wfill), 0);

        phase = "fill";
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 8'(k * 7 + 3), 1'b0);
            if (k == 13) chk("walmostfull_13", 32'(bus.o_walmostfull), 0);
            if (k == 14) chk("walmostfull_14", 32'(bus.o_walmostfull), 1);
            if (k == 15) chk("wfull_15", 32'(bus.o_wfull), 0);
            if (k == 16) chk("wfull_16", 32'(bus.o_wfull), 1);
        end
        cyc(1'b1, 8'hEE, 1'b0);
        chk("wfill_dropped", 32'(bus.o_wfill), 16);
        idle(3);
        chk("rfill_16", 32'(bus.o_rfill), 16);
        for (int k = 0; k < 16; k++) cyc(1'b0, 8'h00, 1'b1);
        chk("rempty_drained", 32'(bus.o_rempty), 1);
        idle(3);
        chk("wfill_drained", 32'(bus.o_wfill), 0);

        phase = "almost_empty";
        for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0);
        idle(3);
        chk("rfill_3", 32'(bus.o_rfill), 3);
        chk("ralmostempty_3", 32'(bus.o_ralmostempty), 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("rfill_2", 32'(bus.o_rfill), 2);
        chk("ralmostempty_2", 32'(bus.o_ralmostempty), 1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        idle(3);

        phase = "simultaneous";
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0);
        idle(3);
        chk("rfill_5", 32'(bus.o_rfill), 5);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 8'($urandom), 1'b1);
            if (k == 3 || k == 6) begin
                chk("wfill_steady", 32'(bus.o_wfill), 8);
                chk("rfill_steady", 32'(bus.o_rfill), 2);
            end
        end
        idle(3);
        chk("rfill_after_simul", 32'(bus.o_rfill), 5);
        for (int i = 0; i < 40 && m_rfill() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
        idle(3);

        phase = "stream";
        start_pop = n_pop;
        nw = 0;
        for (int c = 0; c < 2000 && (n_pop - start_pop) < 50; c++) begin
            wr = (nw < 50) && !bus.o_walmostfull && ($urandom_range(0, 4) != 0);
            rd = !bus.o_rempty && ($urandom_range(0, 3) != 0);
            cyc(wr, 8'($urandom), rd);
            if (wr) nw++;
        end
        chk("stream_pops", 32'(n_pop - start_pop), 50);
        idle(3);

        phase = "midreset";
        for (int k = 0; k < 6; k++) cyc(1'b1, 8'(8'h80 + k), k[0]);
        idle(1);
        rstn = 1'b0;
        cyc(1'b1, 8'h11, 1'b1);
        check_reset_values();
        rstn = 1'b1;
        cyc(1'b1, 8'h3C, 1'b0);
        idle(3);
        chk("post_reset_rempty", 32'(bus.o_rempty), 0);
        chk("post_reset_rdata", 32'(bus.o_rdata), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
